// File: rtl/rx_frame_arbiter_if.sv
// Bundle between rx_frame_arbiter, the four RX PACKET_FIFO read sides and MAC_DEC.
// master = arbiter, slave = FIFO read side plus MAC decoder (or the bench standing in for them).
interface rx_frame_arbiter_if #(
  parameter int PORT_NUM = 4,
  parameter int DATA_W   = 8
);
  // Handshake: the arbiter pulses i_fifo_rden[p] only while o_ready is high and FIFO p is
  // not empty. The FIFO returns that byte and its EOD flag one cycle later, and the arbiter
  // forwards them in that same cycle as a one-cycle o_valid pulse. o_ready gates only new
  // reads, so a byte already read is always delivered.
  logic [PORT_NUM*DATA_W-1:0] i_fifo_dout;
  logic [PORT_NUM-1:0]        i_fifo_empty;
  logic [PORT_NUM-1:0]        i_fifo_del;
  logic [PORT_NUM-1:0]        i_fifo_rden;
  logic                       o_ready;
  logic [DATA_W-1:0]          o_data;
  logic                       o_valid;
  logic                       o_sof;
  logic                       o_eof;
  logic [1:0]                 o_port;
  logic                       o_abort;
  logic [1:0]                 dbg_state;

  modport master (
    input  i_fifo_dout, i_fifo_empty, i_fifo_del, o_ready,
    output i_fifo_rden, o_data, o_valid, o_sof, o_eof, o_port, o_abort, dbg_state
  );

  modport slave (
    output i_fifo_dout, i_fifo_empty, i_fifo_del, o_ready,
    input  i_fifo_rden, o_data, o_valid, o_sof, o_eof, o_port, o_abort, dbg_state
  );
endinterface

// File: rtl/rx_frame_arbiter.sv
// Frame-granular round-robin arbiter from the RX FIFOs to MAC_DEC; one whole frame per grant.
// Optional mid-frame stall abort is enabled by defining RX_ARB_TIMEOUT_EN.
module rx_frame_arbiter #(
  parameter int PORT_NUM = 4,
  parameter int DATA_W   = 8
`ifdef RX_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic               clk,
  input  logic               arst_n,
  rx_frame_arbiter_if.master bus
);
  localparam int PORT_W = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [PORT_W-1:0] ptr_q, ptr_d;
  logic [PORT_W-1:0] port_q, port_d;
  logic              first_q, first_d;

  logic              hit;
  logic [PORT_W-1:0] hit_port;
  logic              sel_empty;
  logic              sel_del;
  logic [DATA_W-1:0] sel_dout;
  logic              rd_fire;
  logic              timeout;

  // Descending scan so the smallest offset from ptr_q wins.
  always_comb begin
    hit      = 1'b0;
    hit_port = ptr_q;
    for (int k = PORT_NUM - 1; k >= 0; k--) begin
      if (!bus.i_fifo_empty[ptr_q + PORT_W'(k)]) begin
        hit      = 1'b1;
        hit_port = ptr_q + PORT_W'(k);
      end
    end
  end

  assign sel_empty = bus.i_fifo_empty[port_q];
  assign sel_del   = bus.i_fifo_del[port_q];
  assign sel_dout  = bus.i_fifo_dout[int'(port_q) * DATA_W +: DATA_W];
  assign rd_fire   = (state_q == ST_REQ) && !sel_empty && bus.o_ready;

`ifdef RX_ARB_TIMEOUT_EN
  logic [11:0] stall_q, stall_d;

  // Counts consecutive empty cycles in REQ; any read or leaving REQ restarts it.
  always_comb begin
    stall_d = stall_q;
    if ((state_q != ST_REQ) || rd_fire) begin
      stall_d = '0;
    end else if (sel_empty) begin
      stall_d = stall_q + 12'd1;
    end
  end

  assign timeout = (state_q == ST_REQ) && sel_empty && (stall_q == 12'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    port_d  = port_q;
    first_d = first_q;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          port_d  = hit_port;
          first_d = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (timeout) begin
          ptr_d   = port_q + 2'd1;
          state_d = ST_IDLE;
        end else if (rd_fire) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        first_d = 1'b0;
        if (sel_del) begin
          ptr_d   = port_q + 2'd1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      port_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      port_q  <= port_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    bus.i_fifo_rden = '0;
    if (rd_fire) begin
      bus.i_fifo_rden[port_q] = 1'b1;
    end
  end

  // The FIFO output registers feed o_data/o_eof directly in WAIT; gated to 0 elsewhere.
  assign bus.o_valid   = (state_q == ST_WAIT);
  assign bus.o_data    = bus.o_valid ? sel_dout : '0;
  assign bus.o_sof     = bus.o_valid & first_q;
  assign bus.o_eof     = bus.o_valid & sel_del;
  assign bus.o_port    = port_q;
  assign bus.o_abort   = timeout;
  assign bus.dbg_state = state_q;
endmodule
